// File: rtl/jtframe_cen_recover_pkg.sv
// rtl/jtframe_cen_recover_pkg.sv - state encoding and default sizing for the cen recovery block
// Shared by the interface, the gap timer and the top (optional JTFRAME_CENREC_STATS_EN lives there).
package jtframe_cenrec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RECOVER = 2'd2
  } cenrec_st_t;

  localparam int CNTW_DEF   = 3;
  localparam int MINGAP_DEF = 2;

endpackage

// File: rtl/jtframe_cen_recover_if.sv
// rtl/jtframe_cen_recover_if.sv - cen gating/recovery signal bundle
// lost_cnt exists only when JTFRAME_CENREC_STATS_EN is defined.
interface jtframe_cen_recover_if
  import jtframe_cenrec_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
);

  logic            cen_in;
  logic            stall;
  logic            rec_en;
  logic            cen_out;
  logic [CNTW-1:0] pending;
  logic            busy;
  logic            overflow;

`ifdef JTFRAME_CENREC_STATS_EN
  logic [15:0]     lost_cnt;

  modport master (
    output cen_in, stall, rec_en,
    input  cen_out, pending, busy, overflow, lost_cnt
  );

  modport slave (
    input  cen_in, stall, rec_en,
    output cen_out, pending, busy, overflow, lost_cnt
  );
`else
  modport master (
    output cen_in, stall, rec_en,
    input  cen_out, pending, busy, overflow
  );

  modport slave (
    input  cen_in, stall, rec_en,
    output cen_out, pending, busy, overflow
  );
`endif

endinterface

// File: rtl/jtframe_cenrec_gap.sv
// rtl/jtframe_cenrec_gap.sv - saturating timer enforcing spacing between cen_out pulses
// fire is the value cen_out takes at the next edge; ok gates the next replay decision.
module jtframe_cenrec_gap
  import jtframe_cenrec_pkg::*;
#(
  parameter int MINGAP = MINGAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic ok
);

  localparam int             GW   = $clog2(MINGAP + 1);
  localparam logic [GW-1:0]  GMAX = GW'(MINGAP);
  localparam logic [GW-1:0]  GREQ = GW'(MINGAP - 1);

  logic [GW-1:0] gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= GMAX;
    end else if (fire) begin
      gap <= '0;
    end else if (gap != GMAX) begin
      gap <= gap + 1'b1;
    end
  end

  // gap is 0 during the cycle a pulse is visible, and the decision lands one
  // clk later, so MINGAP-1 elapsed cycles already yields MINGAP clk spacing.
  assign ok = (gap >= GREQ);

endmodule

// File: rtl/jtframe_cen_recover.sv
// rtl/jtframe_cen_recover.sv - suppresses cen while the CPU bus stalls and replays missed pulses
// Define JTFRAME_CENREC_STATS_EN to add the lost_cnt statistics counter.
module jtframe_cen_recover
  import jtframe_cenrec_pkg::*;
#(
  parameter int CNTW   = CNTW_DEF,
  parameter int MINGAP = MINGAP_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtframe_cen_recover_if.slave bus
);

  localparam logic [CNTW-1:0] PMAX = '1;
  localparam logic [CNTW-1:0] PONE = CNTW'(1);

  cenrec_st_t st;
  logic       gap_ok;
  logic       cnt_ev;
  logic       pend_nz;
  logic       pend_max;
  logic       rec_pulse;
  logic       fire;

  assign pend_nz   = (bus.pending != '0);
  assign pend_max  = (bus.pending == PMAX);
  assign cnt_ev    = bus.cen_in & bus.stall;
  assign rec_pulse = (st == ST_RECOVER) & bus.rec_en & ~bus.stall & ~bus.cen_in
                   & gap_ok & pend_nz;
  // A live pulse always wins over a replayed one; nothing fires while stalled.
  assign fire      = (bus.cen_in & ~bus.stall) | rec_pulse;

  jtframe_cenrec_gap #(
    .MINGAP (MINGAP)
  ) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .fire  (fire),
    .ok    (gap_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ST_IDLE;
      bus.cen_out  <= 1'b0;
      bus.pending  <= '0;
      bus.busy     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.cen_out <= fire;

      if (cnt_ev && pend_max) begin
        bus.overflow <= 1'b1;
      end

      if (!bus.rec_en) begin
        bus.pending <= '0;
      end else if (cnt_ev && !pend_max) begin
        bus.pending <= bus.pending + 1'b1;
      end else if (rec_pulse) begin
        bus.pending <= bus.pending - 1'b1;
      end

      case (st)
        ST_IDLE: begin
          if (bus.stall) begin
            st       <= ST_STALL;
            bus.busy <= 1'b1;
          end
        end
        ST_STALL: begin
          if (!bus.stall) begin
            if (pend_nz && bus.rec_en) begin
              st <= ST_RECOVER;
            end else begin
              st       <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        ST_RECOVER: begin
          if (bus.stall) begin
            st <= ST_STALL;
          end else if (!bus.rec_en || !pend_nz || (rec_pulse && bus.pending == PONE)) begin
            st       <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          st       <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTFRAME_CENREC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lost_cnt <= '0;
    end else if (cnt_ev && (pend_max || !bus.rec_en) && bus.lost_cnt != 16'hFFFF) begin
      bus.lost_cnt <= bus.lost_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtframe_cen_recover.sv
// tb/tb_jtframe_cen_recover.sv - scoreboard bench for jtframe_cen_recover
// Expected cen_out pulse cycles are queued by the stimulus and popped by the monitor.
module tb_jtframe_cen_recover;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_q[$];
  int   exp_c;
  int   k;

  jtframe_cen_recover_if #(.CNTW(3)) bus();

  jtframe_cen_recover #(
    .CNTW   (3),
    .MINGAP (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cen_out) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL cen_out_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        exp_c = exp_q.pop_front();
        if (exp_c != cyc) begin
          errors = errors + 1;
          $display("FAIL cen_out_cycle: pulse at cycle %0d, required cycle %0d", cyc, exp_c);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic r);
    bus.cen_in = c;
    bus.stall  = s;
    bus.rec_en = r;
    @(negedge clk);
  endtask

  task automatic stall_pulses(input int n);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.cen_in = 1'b0;
    bus.stall  = 1'b0;
    bus.rec_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_cen_out", int'(bus.cen_out), 0);
    chk("reset_pending", int'(bus.pending), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);

    // pass-through, cen_in every 8 clk
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(cyc + 1);
      step(1'b1, 1'b0, 1'b1);
      repeat (7) step(1'b0, 1'b0, 1'b1);
      chk("pass_pending", int'(bus.pending), 0);
      chk("pass_busy", int'(bus.busy), 0);
    end

    // three pulses swallowed, replayed 2 clk apart
    stall_pulses(3);
    chk("stall3_pending", int'(bus.pending), 3);
    chk("stall3_busy", int'(bus.busy), 1);
    k = cyc;
    exp_q.push_back(k + 2);
    exp_q.push_back(k + 4);
    exp_q.push_back(k + 6);
    step(1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("rec3_pending", int'(bus.pending), 0);
    chk("rec3_busy", int'(bus.busy), 0);

    // saturation at 7 with nine pulses
    stall_pulses(9);
    chk("sat_pending", int'(bus.pending), 7);
    chk("sat_overflow", int'(bus.overflow), 1);
`ifdef JTFRAME_CENREC_STATS_EN
    chk("sat_lost_cnt", int'(bus.lost_cnt), 2);
`endif
    k = cyc;
    for (int i = 1; i <= 7; i++) exp_q.push_back(k + 2 * i);
    step(1'b0, 1'b0, 1'b1);
    repeat (16) step(1'b0, 1'b0, 1'b1);
    chk("sat_rec_pending", int'(bus.pending), 0);
    chk("sat_rec_busy", int'(bus.busy), 0);
    chk("sat_overflow_sticky", int'(bus.overflow), 1);

    // live pulse during recovery
    stall_pulses(3);
    k = cyc;
    exp_q.push_back(k + 2);
    exp_q.push_back(k + 3);
    exp_q.push_back(k + 5);
    exp_q.push_back(k + 7);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("live_rec_pending", int'(bus.pending), 2);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("live_end_pending", int'(bus.pending), 0);
    chk("live_end_busy", int'(bus.busy), 0);

    // pulse coincident with stall rise is counted, with stall fall passes; then rec_en drop
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("edge_pending", int'(bus.pending), 4);
    exp_q.push_back(cyc + 1);
    step(1'b1, 1'b0, 1'b1);
    chk("fall_pass_pending", int'(bus.pending), 4);
    chk("fall_pass_busy", int'(bus.busy), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("drop_pending", int'(bus.pending), 0);
    chk("drop_busy", int'(bus.busy), 0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // async reset mid-recovery
    stall_pulses(5);
    step(1'b0, 1'b0, 1'b1);
    chk("prerst_pending", int'(bus.pending), 5);
    chk("prerst_busy", int'(bus.busy), 1);
    chk("prerst_overflow", int'(bus.overflow), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cen_out", int'(bus.cen_out), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    bus.cen_in = 1'b0;
    bus.stall  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(cyc + 1);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    chk("postrst_pending", int'(bus.pending), 0);
    chk("postrst_busy", int'(bus.busy), 0);

    chk("pulses_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
